addr_mode_sequencer: RTL and testbench

// Sequential successor to the per-mode addressing flag generators. It owns the address-phase step

---
 rtl/addr_mode_pkg.sv | 68 ++++++
 rtl/addr_mode_step_rom.sv | 11 +
 rtl/addr_mode_sequencer.sv | 150 +++++++++++++++
 tb/tb_addr_mode_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_mode_pkg.sv
// Shared types and the per-mode step table used by the address-phase sequencer
// and the flag ROM.
package addr_mode_pkg;

    localparam int MODE_BITS = 4;
    localparam int INFO_W    = 3;

    typedef enum logic [MODE_BITS-1:0] {
        IMM   = 4'd0,
        IMPL  = 4'd1,
        ZPG   = 4'd2,
        ZPG_X = 4'd3,
        ZPG_Y = 4'd4,
        ABS   = 4'd5,
        ABS_X = 4'd6,
        ABS_Y = 4'd7,
        IND_X = 4'd8,
        IND_Y = 4'd9,
        IND   = 4'd10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [INFO_W-1:0] base_steps;
        logic              has_fix;
        logic [INFO_W-1:0] carry_step;
    } mode_info_t;

    // carry_step is the step at whose end the index carry is sampled; only
    // meaningful for modes with a fix step.
    function automatic mode_info_t mode_info(input mode_t m);
        mode_info_t r;
        r = '{base_steps: 3'd0, has_fix: 1'b0, carry_step: 3'd0};
        case (m)
            ZPG:     r.base_steps = 3'd1;
            ZPG_X:   r.base_steps = 3'd2;
            ZPG_Y:   r.base_steps = 3'd2;
            ABS:     r.base_steps = 3'd2;
            ABS_X:   r = '{base_steps: 3'd2, has_fix: 1'b1, carry_step: 3'd1};
            ABS_Y:   r = '{base_steps: 3'd2, has_fix: 1'b1, carry_step: 3'd1};
            IND_X:   r.base_steps = 3'd4;
            IND_Y:   r = '{base_steps: 3'd3, has_fix: 1'b1, carry_step: 3'd2};
            IND:     r.base_steps = 3'd4;
            default: r.base_steps = 3'd0;
        endcase
        return r;
    endfunction

    function automatic int max_table_steps();
        int         mx;
        int         n;
        mode_info_t inf;
        mx = 0;
        for (int i = 0; i < (1 << MODE_BITS); i++) begin
            inf = mode_info(mode_t'(4'(i)));
            n   = int'(inf.base_steps) + int'(inf.has_fix);
            if (n > mx) mx = n;
        end
        return mx;
    endfunction

endpackage

// File: rtl/addr_mode_step_rom.sv
// Combinational mode -> step-table lookup; the same table feeds the flag ROM.
module addr_mode_step_rom
    import addr_mode_pkg::*;
(
    input  mode_t      mode,
    output mode_info_t info
);

    assign info = mode_info(mode);

endmodule

// File: rtl/addr_mode_sequencer.sv
// Address-phase step sequencer: steps A0..An per addressing mode, inserts the
// page-cross fix step when needed, and honours RDY stalls and aborts.
module addr_mode_sequencer
    import addr_mode_pkg::*;
#(
    parameter int STEP_W          = 3,
    parameter int MODE_W          = 4,
    parameter int MAX_STEPS       = 6,
    parameter int PAGE_PENALTY_EN = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              is_store,
    input  logic              rdy,
    input  logic              abort,
    input  logic              alu_carry,
    output logic              busy,
    output logic [STEP_W-1:0] addr_step,
    output logic              fix_step,
    output logic              store_phase,
    output logic              carry_hold,
    output logic              done
);

    localparam int TABLE_MAX = max_table_steps();

    if (TABLE_MAX > MAX_STEPS) begin : g_table_check
        $error("addr_mode_sequencer: step table needs %0d steps, MAX_STEPS is %0d",
               TABLE_MAX, MAX_STEPS);
    end

    seq_state_t        state;
    mode_t             mode_q;
    logic              store_q;
    mode_t             rom_mode;
    mode_info_t        info;
    logic [STEP_W-1:0] base;
    logic [STEP_W-1:0] carry_idx;
    logic [STEP_W-1:0] step_nxt;
    logic              last_step;
    logic              carry_now;
    logic              take_fix;
    logic              sp_nxt;

    // While idle the table is indexed by the incoming mode so the first step
    // can be set up on the start edge; afterwards by the latched mode.
    addr_mode_step_rom u_rom (
        .mode (rom_mode),
        .info (info)
    );

    always_comb begin
        rom_mode  = (state == IDLE) ? mode_t'(mode) : mode_q;
        base      = STEP_W'(info.base_steps);
        carry_idx = STEP_W'(info.carry_step);
        step_nxt  = addr_step + STEP_W'(1);
        last_step = (addr_step == base - STEP_W'(1));
        // When the carry step is also the last step, the decision must use
        // the live carry, not the value that is only being registered now.
        carry_now = (info.has_fix && (addr_step == carry_idx)) ? alu_carry : carry_hold;
        take_fix  = info.has_fix && (store_q || carry_now || (PAGE_PENALTY_EN == 0));
        sp_nxt    = store_q && !info.has_fix && (step_nxt == base - STEP_W'(1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            mode_q      <= IMPL;
            store_q     <= 1'b0;
            busy        <= 1'b0;
            addr_step   <= '0;
            fix_step    <= 1'b0;
            store_phase <= 1'b0;
            carry_hold  <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            addr_step   <= '0;
            fix_step    <= 1'b0;
            store_phase <= 1'b0;
            carry_hold  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && rdy) begin
                        if (info.base_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= RUN;
                            mode_q      <= mode_t'(mode);
                            store_q     <= is_store;
                            busy        <= 1'b1;
                            addr_step   <= '0;
                            fix_step    <= 1'b0;
                            store_phase <= is_store && !info.has_fix && (base == STEP_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (rdy) begin
                        if (info.has_fix && (addr_step == carry_idx)) begin
                            carry_hold <= alu_carry;
                        end
                        if (last_step) begin
                            if (take_fix) begin
                                state       <= FIX;
                                addr_step   <= base;
                                fix_step    <= 1'b1;
                                store_phase <= store_q;
                            end else begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                addr_step   <= '0;
                                store_phase <= 1'b0;
                                done        <= 1'b1;
                            end
                        end else begin
                            addr_step   <= step_nxt;
                            store_phase <= sp_nxt;
                        end
                    end
                end
                FIX: begin
                    if (rdy) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        addr_step   <= '0;
                        fix_step    <= 1'b0;
                        store_phase <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    carry_hold <= 1'b0;
                end
            endcase
        end
    end

    step_in_range: assert property (@(posedge clk) disable iff (!nrst)
        (int'(addr_step) < MAX_STEPS));

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Directed bench for addr_mode_sequencer: a vector table of whole address
// phases plus hand-written stall, abort, carry and reset sequences.
module tb_addr_mode_sequencer;
    import addr_mode_pkg::*;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [3:0] mode;
    logic       is_store;
    logic       rdy;
    logic       abort;
    logic       alu_carry;

    logic       busy0, fix0, sp0, ch0, done0;
    logic [2:0] step0;
    logic       busy1, fix1, sp1, ch1, done1;
    logic [2:0] step1;

    int n_tests = 0;
    int n_fail  = 0;

    addr_mode_sequencer #(.STEP_W(3), .MODE_W(4), .MAX_STEPS(6), .PAGE_PENALTY_EN(1)) u_dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .is_store(is_store),
        .rdy(rdy), .abort(abort), .alu_carry(alu_carry),
        .busy(busy0), .addr_step(step0), .fix_step(fix0), .store_phase(sp0),
        .carry_hold(ch0), .done(done0)
    );

    addr_mode_sequencer #(.STEP_W(3), .MODE_W(4), .MAX_STEPS(6), .PAGE_PENALTY_EN(0)) u_dut_np (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .is_store(is_store),
        .rdy(rdy), .abort(abort), .alu_carry(alu_carry),
        .busy(busy1), .addr_step(step1), .fix_step(fix1), .store_phase(sp1),
        .carry_hold(ch1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        mode_t m;
        logic  st;
        logic  cy;
        int    len;
        logic  fx;
        logic  sp;
        int    len_np;
        logic  fx_np;
        logic  sp_np;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input int i, input int len,
                               input logic fx, input logic sp, input logic cy,
                               input logic a_busy, input logic [2:0] a_step,
                               input logic a_fix, input logic a_sp,
                               input logic a_ch, input logic a_done);
        bit in_seq;
        bit last;
        in_seq = (i < len);
        last   = in_seq && (i == len - 1);
        chk($sformatf("%s c%0d busy", tag, i), int'(a_busy), int'(in_seq));
        chk($sformatf("%s c%0d addr_step", tag, i), int'(a_step), in_seq ? i : 0);
        chk($sformatf("%s c%0d fix_step", tag, i), int'(a_fix), int'(last && fx));
        chk($sformatf("%s c%0d store_phase", tag, i), int'(a_sp), int'(last && sp));
        chk($sformatf("%s c%0d done", tag, i), int'(a_done), int'(i == len));
        if (last && fx) chk($sformatf("%s c%0d carry_hold", tag, i), int'(a_ch), int'(cy));
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   n;
        v         = vecs[k];
        mode      = v.m;
        is_store  = v.st;
        alu_carry = v.cy;
        start     = 1'b1;
        step();
        start = 1'b0;
        n = ((v.len > v.len_np) ? v.len : v.len_np) + 2;
        for (int i = 0; i < n; i++) begin
            check_cycle($sformatf("v%0d", k), i, v.len, v.fx, v.sp, v.cy,
                        busy0, step0, fix0, sp0, ch0, done0);
            check_cycle($sformatf("v%0d_np", k), i, v.len_np, v.fx_np, v.sp_np, v.cy,
                        busy1, step1, fix1, sp1, ch1, done1);
            step();
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        vecs[0]  = '{ZPG,   1'b0, 1'b0, 1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[1]  = '{ZPG,   1'b1, 1'b0, 1, 1'b0, 1'b1, 1, 1'b0, 1'b1};
        vecs[2]  = '{ZPG_X, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[3]  = '{ZPG_Y, 1'b1, 1'b0, 2, 1'b0, 1'b1, 2, 1'b0, 1'b1};
        vecs[4]  = '{ABS,   1'b0, 1'b1, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[5]  = '{ABS,   1'b1, 1'b0, 2, 1'b0, 1'b1, 2, 1'b0, 1'b1};
        vecs[6]  = '{ABS_X, 1'b0, 1'b0, 2, 1'b0, 1'b0, 3, 1'b1, 1'b0};
        vecs[7]  = '{ABS_X, 1'b0, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b0};
        vecs[8]  = '{ABS_Y, 1'b1, 1'b0, 3, 1'b1, 1'b1, 3, 1'b1, 1'b1};
        vecs[9]  = '{ABS_Y, 1'b0, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b0};
        vecs[10] = '{IND_X, 1'b0, 1'b1, 4, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[11] = '{IND_X, 1'b1, 1'b0, 4, 1'b0, 1'b1, 4, 1'b0, 1'b1};
        vecs[12] = '{IND_Y, 1'b0, 1'b0, 3, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[13] = '{IND_Y, 1'b0, 1'b1, 4, 1'b1, 1'b0, 4, 1'b1, 1'b0};
        vecs[14] = '{IND_Y, 1'b1, 1'b0, 4, 1'b1, 1'b1, 4, 1'b1, 1'b1};
        vecs[15] = '{IND,   1'b0, 1'b0, 4, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[16] = '{IMM,   1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[17] = '{IMPL,  1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        nrst      = 1'b0;
        start     = 1'b0;
        mode      = IMPL;
        is_store  = 1'b0;
        rdy       = 1'b1;
        abort     = 1'b0;
        alu_carry = 1'b0;
        #12;
        chk("reset busy", int'(busy0), 0);
        chk("reset addr_step", int'(step0), 0);
        chk("reset fix_step", int'(fix0), 0);
        chk("reset store_phase", int'(sp0), 0);
        chk("reset carry_hold", int'(ch0), 0);
        chk("reset done", int'(done0), 0);
        nrst = 1'b1;
        step();

        for (int k = 0; k < 18; k++) run_vec(k);

        // IND_Y with carry only at the end of step 2
        mode = IND_Y; is_store = 1'b0; alu_carry = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step();
        step();
        chk("indy step2 addr_step", int'(step0), 2);
        chk("indy step2 carry_hold", int'(ch0), 0);
        alu_carry = 1'b1;
        step();
        alu_carry = 1'b0;
        chk("indy fix addr_step", int'(step0), 3);
        chk("indy fix fix_step", int'(fix0), 1);
        chk("indy fix carry_hold", int'(ch0), 1);
        step();
        chk("indy done", int'(done0), 1);
        step();
        chk("indy idle carry_hold", int'(ch0), 0);
        chk("indy idle done", int'(done0), 0);

        // IND_X with a three-cycle stall at step 2 and a start while busy
        mode = IND_X; is_store = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy0) busy_cnt++;
            if (done0) done_cnt++;
            if (c >= 2 && c <= 5) chk($sformatf("stall c%0d addr_step", c), int'(step0), 2);
            if (c == 1) begin
                start = 1'b1;
                mode  = ZPG;
            end else begin
                start = 1'b0;
            end
            rdy = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            step();
        end
        rdy = 1'b1;
        chk("stall busy cycles", busy_cnt, 7);
        chk("stall done pulses", done_cnt, 1);

        // abort at ABS step 1
        mode = ABS; is_store = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("abort pre addr_step", int'(step0), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", int'(busy0), 0);
        chk("abort done", int'(done0), 0);
        step();
        chk("abort after done", int'(done0), 0);
        chk("abort after busy", int'(busy0), 0);

        // start presented during the DONE cycle is ignored
        mode = ZPG; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("done-start done", int'(done0), 1);
        mode = ABS; start = 1'b1;
        step(); start = 1'b0;
        chk("done-start busy", int'(busy0), 0);
        chk("done-start done2", int'(done0), 0);
        step();

        // asynchronous reset in the middle of a store sequence
        mode = IND; is_store = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("pre-reset busy", int'(busy0), 1);
        nrst = 1'b0;
        #1;
        chk("async reset busy", int'(busy0), 0);
        chk("async reset addr_step", int'(step0), 0);
        chk("async reset store_phase", int'(sp0), 0);
        chk("async reset done", int'(done0), 0);
        #2;
        nrst = 1'b1;
        step();
        chk("post-reset busy", int'(busy0), 0);
        chk("post-reset done", int'(done0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
